// File: rtl/single_cycle.sv
// RV32I single-cycle core: fetch, decode, execute and retire one instruction
// per enabled rising edge. Instruction memory is external (addressed by
// pc_out); register file and word-organised data memory are internal.
// There is no handshake: the instruction word is assumed valid
// combinationally for the current pc_out, and en=0 simply freezes all state.
module single_cycle #(
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] res_out
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Architectural state
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] dmem_q [DMEM_DEPTH];

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Register reads; x0 is hard-wired to zero regardless of array contents
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    // Data memory addressing: one adder serves both loads and stores
    logic [31:0]   mem_addr;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign mem_idx  = mem_addr[AW+1:2];
    assign mem_word = dmem_q[mem_idx];
    assign ld_byte  = mem_word[{mem_addr[1:0], 3'b000} +: 8];
    assign ld_half  = mem_addr[1] ? mem_word[31:16] : mem_word[15:0];

    // Address bits above the memory window are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:AW+2]};

    // Shared ALU for register and immediate forms; alt selects SUB / SRA
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Decode/execute: next PC, write-back value, store request and result
    logic        wb_we;
    logic [31:0] wb_data;
    logic        st_we;
    logic        br_taken;
    logic [31:0] res_d;

    always_comb begin
        pc_d     = pc_q + 32'd4;
        wb_we    = 1'b0;
        wb_data  = 32'd0;
        st_we    = 1'b0;
        br_taken = 1'b0;
        res_d    = 32'd0;
        case (opcode)
            OP_LUI: begin
                wb_we   = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_we   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OP_JAL: begin
                wb_we   = 1'b1;
                wb_data = pc_q + 32'd4;
                pc_d    = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    wb_we   = 1'b1;
                    wb_data = pc_q + 32'd4;
                    pc_d    = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  br_taken = (rs1_val == rs2_val);
                    3'b001:  br_taken = (rs1_val != rs2_val);
                    3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
                    3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  br_taken = (rs1_val < rs2_val);
                    3'b111:  br_taken = (rs1_val >= rs2_val);
                    default: br_taken = 1'b0;
                endcase
                if (br_taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OP_LOAD: begin
                wb_we = 1'b1;
                case (funct3)
                    3'b000:  wb_data = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  wb_data = {{16{ld_half[15]}}, ld_half};
                    3'b010:  wb_data = mem_word;
                    3'b100:  wb_data = {24'd0, ld_byte};
                    3'b101:  wb_data = {16'd0, ld_half};
                    default: wb_we   = 1'b0;
                endcase
            end
            OP_STORE: begin
                st_we = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OP_IMM: begin
                if (funct3 == 3'b001) begin
                    wb_we = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    wb_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    wb_we = 1'b1;
                end
                if (wb_we) begin
                    wb_data = alu(rs1_val, imm_i, funct3, (funct3 == 3'b101) && funct7[5]);
                end
            end
            OP_REG: begin
                wb_we = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                if (wb_we) begin
                    wb_data = alu(rs1_val, rs2_val, funct3, funct7[5]);
                end
            end
            default: begin
                wb_we = 1'b0;
            end
        endcase
        if (wb_we) begin
            res_d = wb_data;
        end else if (st_we) begin
            res_d = mem_addr;
        end
    end

    // Store lane selection: replicate the source so each lane sees its byte
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = rs2_val;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << mem_addr[1:0];
                st_wdata = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = rs2_val;
            end
        endcase
    end

    // PC and register file update; reset wins over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (en) begin
            pc_q <= pc_d;
            if (wb_we && (rd != 5'd0)) begin
                regs_q[rd] <= wb_data;
            end
        end
    end

    // Data memory byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && en && st_we) begin
            for (int k = 0; k < 4; k++) begin
                if (st_be[k]) begin
                    dmem_q[mem_idx][8*k +: 8] <= st_wdata[8*k +: 8];
                end
            end
        end
    end

    assign pc_out  = pc_q;
    assign res_out = res_d;

endmodule

// File: tb/tb_single_cycle.sv
// Bench for single_cycle: ISA-level reference model (byte-addressed memory,
// per-mnemonic semantics) checked every negedge, directed sequences with
// hand-computed literals, randomized instruction stream and mid-run reset.
module tb_single_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] res_out;

    int checks   = 0;
    int failures = 0;

    // Clock / DUT
    always #5 clk = ~clk;

    single_cycle #(
        .DMEM_DEPTH(256),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .instruction(instruction),
        .pc_out     (pc_out),
        .res_out    (res_out)
    );

    // Reference model state
    bit          model_valid = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic [7:0]  m_mem [1024];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rr(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : m_regs[r];
    endfunction

    // Architectural effect of one instruction from the current model state
    task automatic model_eval(input logic [31:0] ins, output logic [31:0] npc,
                              output logic [31:0] res, output bit wr,
                              output logic [31:0] wbv, output int st_n,
                              output logic [9:0] st_a, output logic [31:0] st_v);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  sh;
        logic [31:0] a, b, ii, is, ib, iu, ij, ea, wd;
        logic [9:0]  ha, wa;
        logic [15:0] hw;
        logic [7:0]  by;
        bit          t, ok;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        sh = ins[24:20];
        a  = rr(ins[19:15]);
        b  = rr(ins[24:20]);
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'd0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = m_pc + 32'd4;
        res = 32'd0; wr = 1'b0; wbv = 32'd0; st_n = 0; st_a = 10'd0; st_v = b;
        t = 1'b0; ok = 1'b1;
        ea = a + ((op == 7'h23) ? is : ii);
        by = m_mem[ea[9:0]];
        ha = {ea[9:1], 1'b0};
        hw = {m_mem[ha + 10'd1], m_mem[ha]};
        wa = {ea[9:2], 2'b00};
        wd = {m_mem[wa + 10'd3], m_mem[wa + 10'd2], m_mem[wa + 10'd1], m_mem[wa]};
        case (op)
            7'h37: begin wr = 1'b1; wbv = iu; end
            7'h17: begin wr = 1'b1; wbv = m_pc + iu; end
            7'h6f: begin wr = 1'b1; wbv = m_pc + 32'd4; npc = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin
                wr = 1'b1; wbv = m_pc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = ($signed(a) >= $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = (a >= b);
                    default: ok = 1'b0;
                endcase
                if (ok && t) npc = m_pc + ib;
            end
            7'h03: begin
                wr = 1'b1;
                case (f3)
                    3'd0: wbv = {{24{by[7]}}, by};
                    3'd1: wbv = {{16{hw[15]}}, hw};
                    3'd2: wbv = wd;
                    3'd4: wbv = {24'd0, by};
                    3'd5: wbv = {16'd0, hw};
                    default: wr = 1'b0;
                endcase
            end
            7'h23: begin
                case (f3)
                    3'd0: begin st_n = 1; st_a = ea[9:0]; end
                    3'd1: begin st_n = 2; st_a = ha; end
                    3'd2: begin st_n = 4; st_a = wa; end
                    default: st_n = 0;
                endcase
                if (st_n != 0) res = ea;
            end
            7'h13: begin
                wr = 1'b1;
                case (f3)
                    3'd0: wbv = a + ii;
                    3'd2: wbv = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd3: wbv = (a < ii) ? 32'd1 : 32'd0;
                    3'd4: wbv = a ^ ii;
                    3'd6: wbv = a | ii;
                    3'd7: wbv = a & ii;
                    3'd1: if (f7 == 7'h00) wbv = a << sh; else wr = 1'b0;
                    default: begin
                        if (f7 == 7'h00) wbv = a >> sh;
                        else if (f7 == 7'h20) wbv = $unsigned($signed(a) >>> sh);
                        else wr = 1'b0;
                    end
                endcase
            end
            7'h33: begin
                wr = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: wbv = a + b;
                        3'd1: wbv = a << b[4:0];
                        3'd2: wbv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: wbv = (a < b) ? 32'd1 : 32'd0;
                        3'd4: wbv = a ^ b;
                        3'd5: wbv = a >> b[4:0];
                        3'd6: wbv = a | b;
                        default: wbv = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    wbv = a - b;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    wbv = $unsigned($signed(a) >>> b[4:0]);
                end else begin
                    wr = 1'b0;
                end
            end
            default: wr = 1'b0;
        endcase
        if (wr) res = wbv;
    endtask

    // Model commit on every rising edge
    logic [31:0] u_npc, u_res, u_wbv, u_v;
    bit          u_wr;
    int          u_n;
    logic [9:0]  u_a;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0000_0000;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            model_valid = 1'b1;
        end else if (en && model_valid) begin
            model_eval(instruction, u_npc, u_res, u_wr, u_wbv, u_n, u_a, u_v);
            if (u_wr && instruction[11:7] != 5'd0) m_regs[instruction[11:7]] = u_wbv;
            for (int k = 0; k < u_n; k++) m_mem[u_a + 10'(k)] = u_v[8*k +: 8];
            m_pc = u_npc;
        end
    end

    // Compare process: outputs checked against the model every negedge
    logic [31:0] c_npc, c_res, c_wbv, c_v;
    bit          c_wr;
    int          c_n;
    logic [9:0]  c_a;

    always @(negedge clk) begin
        if (model_valid) begin
            model_eval(instruction, c_npc, c_res, c_wr, c_wbv, c_n, c_a, c_v);
            check("cmp_pc", pc_out, m_pc);
            check("cmp_res", res_out, c_res);
        end
    end

    // Encoders for random stimulus
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] probe(input logic [4:0] r);
        return enc_r(7'h00, 5'd0, r, 3'd0, 5'd0, 7'h33);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] rnd;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        rnd = $urandom();
        rd  = 5'($urandom_range(0, 31));
        r1  = 5'($urandom_range(0, 31));
        r2  = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
            0: f7 = 7'h20;
            1: f7 = 7'h01;
            default: f7 = 7'h00;
        endcase
        case ($urandom_range(0, 10))
            0, 1: return enc_r(f7, r2, r1, f3, rd, 7'h33);
            2, 3: begin
                if (f3 == 3'd1 || f3 == 3'd5) return enc_i({f7, r2}, r1, f3, rd, 7'h13);
                return enc_i(rnd[11:0], r1, f3, rd, 7'h13);
            end
            4: return {rnd[31:12], rd, (rnd[0] ? 7'h37 : 7'h17)};
            5: return enc_j(rnd[20:0], rd);
            6: return enc_i(rnd[11:0], r1, (rnd[12] ? f3 : 3'd0), rd, 7'h67);
            7: return enc_b(rnd[12:0], r2, r1, f3);
            8: return enc_i(12'($urandom_range(0, 63)), 5'd0, f3, rd, 7'h03);
            9: return enc_s(12'($urandom_range(0, 63)), r2, 5'd0, 3'($urandom_range(0, 3)));
            default: begin
                case (rnd[1:0])
                    2'd0: return 32'h0000_000F;
                    2'd1: return 32'h0000_0073;
                    2'd2: return 32'h0010_0073;
                    default: return {rnd[31:7], 7'h7f};
                endcase
            end
        endcase
    endfunction

    // Driver: apply inputs just after a rising edge, settle 1 time unit
    task automatic step(input logic [31:0] ins, input logic e);
        @(posedge clk);
        #2;
        instruction = ins;
        en          = e;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        instruction = 32'd0;
        @(posedge clk);
        #2;
        rst         = 1'b0;
        instruction = 32'h0050_0093;
        #1;
        check("reset_pc", pc_out, 32'h0);
        check("stall_res", res_out, 32'h5);
        step(32'h0050_0093, 1'b0);
        step(32'h0050_0093, 1'b0);
        check("stall_pc", pc_out, 32'h0);
        step(probe(5'd1), 1'b0);
        check("stall_x1", res_out, 32'h0);

        // ALU sequence
        step(32'h0050_0093, 1'b1);
        check("addi_res", res_out, 32'h5);
        check("addi_pc", pc_out, 32'h0);
        step(32'hFFD0_0113, 1'b1);
        check("addi_neg_res", res_out, 32'hFFFF_FFFD);
        check("addi_neg_pc", pc_out, 32'h4);
        step(32'h0020_81B3, 1'b1);
        check("add_res", res_out, 32'h2);
        check("add_pc", pc_out, 32'h8);

        // Memory
        step(32'h1234_5237, 1'b1);
        check("lui_res", res_out, 32'h1234_5000);
        check("lui_pc", pc_out, 32'hC);
        step(32'h0040_2423, 1'b1);
        check("sw_res", res_out, 32'h8);
        step(32'h0090_0283, 1'b1);
        check("lb_res", res_out, 32'h0000_0050);
        step(32'h00A0_1303, 1'b1);
        check("lh_res", res_out, 32'h0000_1234);

        // x0 write is discarded
        step(32'h0070_0013, 1'b1);
        check("addi_x0_res", res_out, 32'h7);
        step(probe(5'd0), 1'b0);
        check("x0_read", res_out, 32'h0);
        check("pre_jal_pc", pc_out, 32'h20);

        // Jump and branches
        step(32'h0100_00EF, 1'b1);
        check("jal_res", res_out, 32'h24);
        step(probe(5'd1), 1'b1);
        check("jal_pc", pc_out, 32'h30);
        check("jal_x1", res_out, 32'h24);
        step(32'h0000_0463, 1'b1);
        check("beq_res", res_out, 32'h0);
        step(32'h0000_1463, 1'b1);
        check("beq_pc", pc_out, 32'h3C);
        check("bne_res", res_out, 32'h0);
        step(probe(5'd0), 1'b0);
        check("bne_pc", pc_out, 32'h40);

        // Seed registers and the first 64 bytes of data memory
        for (int r = 1; r < 32; r++) begin
            step({20'($urandom()), 5'(r), 7'h37}, 1'b1);
            step(enc_i(12'($urandom()), 5'(r), 3'd0, 5'(r), 7'h13), 1'b1);
        end
        for (int w = 0; w < 16; w++) begin
            step(enc_s(12'(4 * w), 5'(w + 1), 5'd0, 3'd2), 1'b1);
        end

        // Randomized stream with occasional stalls
        for (int n = 0; n < 800; n++) begin
            step(rand_instr(), ($urandom_range(0, 9) != 0));
        end

        // Mid-run reset with en=1 and a register write pending
        @(posedge clk);
        #2;
        rst         = 1'b1;
        en          = 1'b1;
        instruction = 32'h0050_0093;
        @(posedge clk);
        #2;
        rst         = 1'b0;
        en          = 1'b0;
        instruction = probe(5'd1);
        #1;
        check("midreset_pc", pc_out, 32'h0);
        check("midreset_x1", res_out, 32'h0);
        for (int r = 2; r < 32; r++) begin
            step(probe(5'(r)), 1'b0);
            check("midreset_xn", res_out, 32'h0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/single_cycle.md
Name: single_cycle

Overview:
- RV32I single-cycle processor core: one instruction fetched, decoded, executed and retired per enabled clock edge.
- Instruction word arrives on an input port from an external instruction memory addressed by pc_out.
- Contains a 32x32 register file, ALU, branch unit, immediate generator and a word-organised data memory.
- Top-level core of the single-cycle build.

Parameters:
- DMEM_DEPTH, 256, data memory depth in 32-bit words; byte address indexed by addr[log2(DMEM_DEPTH)+1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  enable; 0 = stall (no PC, register-file or memory update).
- instruction  input  32  instruction word located at pc_out, valid combinationally.
- pc_out  output  32  current PC.
- res_out  output  32  combinational result of the current instruction (see Behaviour).

Behaviour:
- Reset: rst=1 at a rising edge sets PC=RESET_PC and clears x1..x31 to 0. rst has priority over en. Data memory is not reset.
- Retire: on a rising edge with rst=0 and en=1:
  - PC <= next_pc.
  - rd <= wb_data if the instruction writes rd and rd!=0.
  - Store bytes are written.
- Stall: en=0 holds all state; outputs still track the instruction combinationally.
- Register file: combinational reads; x0 always reads 0; writes to x0 ignored.
- next_pc: PC+4 by default.
  - Taken branch: PC+immB.
  - JAL: PC+immJ.
  - JALR: (rs1+immI) & ~1.
  - No misalignment trap; bit 1 of the target is kept.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU; SB, SH, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Unsupported opcodes/funct (FENCE, ECALL, EBREAK, illegal): act as NOP, PC+4, no writes, res_out=0.
- Arithmetic: modulo 2^32. Shift amount is rs2[4:0] or imm[4:0]. SLT/BLT/BGE are signed; SLTU/BLTU/BGEU unsigned.
- Memory: little-endian.
  - Effective address = rs1+immI (loads) or rs1+immS (stores).
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. No trap.
  - Stores use byte-lane enables.
  - Loads are combinational reads; LB/LH sign-extend, LBU/LHU zero-extend.
- res_out:
  - Instructions writing rd: the wb_data, even if rd=x0.
  - Stores: the effective address.
  - Branches: 0.

Test Plan:
- Reset/stall: rst=1 for one edge -> pc_out=0. Then rst=0, en=0, instruction=0x00500093 (ADDI x1,x0,5) for 3 edges -> pc_out stays 0, res_out=5, x1 remains 0.
- ALU sequence, en=1: 0x00500093, then 0xFFD00113 (ADDI x2,x0,-3), then 0x002081B3 (ADD x3,x1,x2) -> res_out 5, 0xFFFFFFFD, 2; pc_out 0, 4, 8, 12.
- Memory:
  - 0x12345237 (LUI x4,0x12345) -> res_out 0x12345000.
  - 0x00402423 (SW x4,8(x0)) -> res_out 8.
  - 0x00900283 (LB x5,9(x0)) -> 0x00000050.
  - 0x00A01303 (LH x6,10(x0)) -> 0x00001234.
- Branches at PC P: 0x00000463 (BEQ x0,x0,+8) -> pc_out P+8. 0x00001463 (BNE x0,x0,+8) -> pc_out P+4, res_out 0.
- Jump: 0x010000EF (JAL x1,+16) at PC 0x20 -> pc_out 0x30, x1=res_out=0x24.
- x0 and reset mid-run: 0x00700013 (ADDI x0,x0,7) -> res_out 7, x0 still reads 0. Then assert rst for one edge mid-program -> pc_out=0, x1..x31 read 0.
